hammu_bcd_conv: RTL and testbench
=================================

Name: hammu_bcd_conv

Overview:
Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) directly downstream of the power unit.
- Consumes the unit's 30-bit result and its level-held done flag.
- Produces packed BCD digits for the display/readback path of the Ham_Mu AXI4-Lite peripheral.
- One bit is converted per clock.

Parameters:
- DATA_W, 30, width of the binary input.
- DIGITS, 10, number of BCD output digits. Must satisfy 10^DIGITS > 2^DATA_W - 1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  level "result ready" (power unit's o_done); a conversion starts on its rising edge.
- i_bin  input  DATA_W  binary value; sampled only on the cycle the rising edge is detected.
- o_busy  output  1  high while in SHIFT.
- o_done  output  1  high while in DONE; o_bcd valid.
- o_bcd  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].

Behaviour:
- Reset (async, i_rst_n low):
  - state=IDLE; o_busy=0, o_done=0, o_bcd=0.
  - Shift register, digit accumulator, iteration counter and i_valid edge-detect register all cleared to 0.
  - Reset mid-conversion aborts it with no residual state.
- Edge detect: registered copy v_q of i_valid; rise = i_valid & ~v_q.
  - v_q resets to 0, so i_valid already high at reset release counts as a rise on the first clock.
- States:
  - IDLE: o_busy=0, o_done=0, o_bcd holds its last value. On rise (cycle T): load shift reg with i_bin, clear accumulator, counter=0, go SHIFT.
  - SHIFT: o_busy=1. Each cycle:
    - every 4-bit digit >=5 gets +3 (combinational);
    - then {accumulator, shift reg} shifts left 1; counter++.
    - When counter reaches DATA_W-1 (the last shift done this cycle), go DONE.
    - Occupies cycles T+1..T+DATA_W.
  - DONE: o_done=1, o_bcd = final accumulator.
    - Registered, first visible at T+DATA_W+1; total latency DATA_W+1 = 31 clocks from rise.
    - Stays until i_valid is low, then returns to IDLE (o_done drops next cycle).
- Rises of i_valid while in SHIFT or DONE are ignored. i_bin changes after T are ignored.
- Counter width: $clog2(DATA_W). No wrap occurs because the counter stops at DATA_W-1.
- Arithmetic:
  - Digit adjust is 4-bit.
  - No overflow possible given the DIGITS constraint.
  - Inputs with all bits set convert exactly (2^30-1 -> 1073741823).
- Simultaneous reset and rise: reset wins.

Optional Feature:
- Macro HAMMU_BCD_BLANK_EN.
- Defined: in DONE, o_bcd leading-zero digits (all digits above the most significant nonzero digit) are replaced with 4'hF (blank code). Digit 0 is never blanked, so value 0 -> all 4'hF except digit0=0. Blanking is computed combinationally from the accumulator and registered into o_bcd on entry to DONE, so latency is unchanged.
- Undefined: raw BCD with leading zeros, no extra logic.

Decomposition:
- Shared package hammu_pkg:
  - HAMMU_DATA_W=30, HAMMU_DIGITS=10;
  - state encoding localparams IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - BCD_BLANK=4'hF.
- One natural sub-module: hammu_bcd_adj3, a combinational 4-bit "if >=5 add 3" cell instantiated DIGITS times via generate. The FSM, counter and shift path stay in the top.

Test Plan:
- Reset, then i_valid rises with i_bin=81 (3^4) -> o_busy high T+1..T+30; o_done=1 at T+31; o_bcd=40'h0000000081.
- i_bin=30'h3FFFFFFF -> o_bcd=40'h1073741823 after 31 clocks.
- i_bin=0 -> o_bcd=0. With HAMMU_BCD_BLANK_EN: 40'hFFFFFFFFF0. Also 170859375 (15^7) with macro -> 40'hF170859375.
- i_valid held high across the entire conversion and 20 extra cycles, i_bin changed at T+5 -> exactly one conversion, result reflects value at T, o_done stays 1; i_valid low -> o_done 0 next cycle, o_bcd retained.
- Assert i_rst_n low at T+12 mid-SHIFT -> all outputs 0 immediately; release with i_valid low -> IDLE, no o_done. Release with i_valid high -> new conversion starts.
- Back-to-back: done, i_valid low one cycle, rise with i_bin=1000 -> second result 40'h0000001000 at 31 clocks after the second rise.

Source files
------------

// File: rtl/hammu_pkg.sv
// ---------------------------------------------------------------------------
// hammu_pkg
// Shared constants for the Ham_Mu binary-to-BCD conversion path.
//   HAMMU_DATA_W : width of the power unit result (binary input)
//   HAMMU_DIGITS : number of packed BCD digits produced
//   IDLE/SHIFT/DONE : converter state encodings
//   BCD_BLANK    : digit code shown in place of a leading zero when the
//                  HAMMU_BCD_BLANK_EN build option is enabled
// ---------------------------------------------------------------------------
package hammu_pkg;

   localparam int HAMMU_DATA_W = 30;
   localparam int HAMMU_DIGITS = 10;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] DONE  = 2'b10;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_DONE  = DONE
   } state_t;

endpackage

// File: rtl/hammu_bcd_adj3.sv
// ---------------------------------------------------------------------------
// hammu_bcd_adj3
// Combinational double-dabble correction cell: a BCD digit of 5 or more gets
// 3 added so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   digit_in  : 4-bit BCD digit before correction
//   digit_out : 4-bit corrected digit
// ---------------------------------------------------------------------------
module hammu_bcd_adj3 (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   always_comb begin
      digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
   end

endmodule

// File: rtl/hammu_bcd_conv.sv
// ---------------------------------------------------------------------------
// hammu_bcd_conv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, sitting directly behind the Ham_Mu power unit.
// A conversion starts on the rising edge of i_valid, runs DATA_W shift
// cycles, then holds the result in DONE until i_valid goes low.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_valid : level "result ready" from the power unit
//   i_bin   : binary value, captured on the cycle the rise is seen
//   o_busy  : high while shifting
//   o_done  : high while the result in o_bcd is valid
//   o_bcd   : packed BCD, digit 0 (ones) in bits [3:0]
// Build option:
//   HAMMU_BCD_BLANK_EN : when defined, leading-zero digits of the result
//                        (never digit 0) are replaced by BCD_BLANK.
// ---------------------------------------------------------------------------
module hammu_bcd_conv
   import hammu_pkg::*;
#(
   parameter int DATA_W = HAMMU_DATA_W,
   parameter int DIGITS = HAMMU_DIGITS
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [DATA_W-1:0]     i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W);

   state_t                    state;
   state_t                    state_nxt;
   logic                      v_q;
   logic                      rise;
   logic [DATA_W-1:0]         shreg;
   logic [BCD_W-1:0]          acc;
   logic [CNT_W-1:0]          cnt;
   logic                      last_shift;
   logic [BCD_W-1:0]          acc_adj;
   logic [BCD_W+DATA_W-1:0]   shifted;
   logic [BCD_W-1:0]          acc_shift;
   logic [DATA_W-1:0]         sh_shift;
   logic [BCD_W-1:0]          bcd_final;

   assign rise       = i_valid & ~v_q;
   assign last_shift = (cnt == CNT_W'(DATA_W - 1));

   // Per-digit add-3 correction ahead of each shift.
   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      hammu_bcd_adj3 u_adj (
         .digit_in  (acc[4*d +: 4]),
         .digit_out (acc_adj[4*d +: 4])
      );
   end

   // Accumulator and shift register move left together as one long word;
   // the top bit shifted out of the accumulator is always 0 because DIGITS
   // is sized to hold the largest input.
   assign shifted   = {acc_adj, shreg} << 1;
   assign acc_shift = shifted[BCD_W+DATA_W-1:DATA_W];
   assign sh_shift  = shifted[DATA_W-1:0];

`ifdef HAMMU_BCD_BLANK_EN
   // Blank every digit above the most significant nonzero one; digit 0 is
   // always shown so a zero result still reads as "0".
   always_comb begin
      logic seen;
      seen      = 1'b0;
      bcd_final = acc_shift;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (!seen && (acc_shift[4*i +: 4] == 4'd0)) begin
            bcd_final[4*i +: 4] = BCD_BLANK;
         end else begin
            seen = 1'b1;
         end
      end
   end
`else
   assign bcd_final = acc_shift;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs. Rises seen outside IDLE are ignored.
   always_comb begin
      state_nxt = state;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            o_busy = 1'b1;
            if (last_shift) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_done = 1'b1;
            if (!i_valid) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: edge detect, operand capture, shifting and result register.
   // The result is registered on the last shift so it appears together with
   // the DONE state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_q   <= 1'b0;
         shreg <= '0;
         acc   <= '0;
         cnt   <= '0;
         o_bcd <= '0;
      end else begin
         v_q <= i_valid;
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  shreg <= i_bin;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               acc   <= acc_shift;
               shreg <= sh_shift;
               if (last_shift) begin
                  o_bcd <= bcd_final;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hammu_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_hammu_bcd_conv
// Self-checking bench for hammu_bcd_conv. A behavioural model derives the
// expected busy/done/result timeline from the i_valid rise and converts the
// captured value to decimal with plain arithmetic; a compare process checks
// the DUT against it every cycle. Directed cases pin literal results and
// latencies. Honours HAMMU_BCD_BLANK_EN for the expected result format.
// ---------------------------------------------------------------------------
module tb_hammu_bcd_conv;

   localparam int DATA_W = 30;
   localparam int DIGITS = 10;

   logic                i_clk   = 1'b0;
   logic                i_rst_n = 1'b0;
   logic                i_valid = 1'b0;
   logic [DATA_W-1:0]   i_bin   = '0;
   logic                o_busy;
   logic                o_done;
   logic [4*DIGITS-1:0] o_bcd;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model state
   logic                m_vq   = 1'b0;
   logic                m_busy = 1'b0;
   logic                m_done = 1'b0;
   logic [4*DIGITS-1:0] m_bcd  = '0;
   logic [DATA_W-1:0]   m_val  = '0;
   int                  m_left = 0;

   hammu_bcd_conv #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .i_bin   (i_bin),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_bcd   (o_bcd)
   );

   always #5 i_clk = ~i_clk;

   // Decimal digits by repeated division; optional leading-zero blanking by
   // counting the decimal length of the value.
   function automatic logic [4*DIGITS-1:0] model_bcd(input logic [DATA_W-1:0] v);
      logic [4*DIGITS-1:0] r;
      longint t;
      int nd;
      r = '0;
      t = longint'(v);
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
`ifdef HAMMU_BCD_BLANK_EN
      nd = 1;
      t = longint'(v);
      while (t >= 10) begin
         t = t / 10;
         nd++;
      end
      for (int i = nd; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'hF;
      end
`else
      nd = 0;
`endif
      return r;
   endfunction

   function automatic logic [4*DIGITS-1:0] pick(input logic [4*DIGITS-1:0] raw,
                                                input logic [4*DIGITS-1:0] blank);
`ifdef HAMMU_BCD_BLANK_EN
      return blank;
`else
      return raw;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [4*DIGITS-1:0] got,
                              input logic [4*DIGITS-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural timeline: after a rise the result appears DATA_W+1 clocks
   // later and is held until i_valid is seen low.
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_vq   <= 1'b0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_bcd  <= '0;
         m_left <= 0;
      end else begin
         m_vq <= i_valid;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_bcd  <= model_bcd(m_val);
            end
            m_left <= m_left - 1;
         end else if (m_done) begin
            if (!i_valid) m_done <= 1'b0;
         end else if (i_valid && !m_vq) begin
            m_val  <= i_bin;
            m_left <= DATA_W;
            m_busy <= 1'b1;
         end
      end
   end

   always @(negedge i_clk) begin
      if (chk_en) begin
         checkOutput("busy", 40'(o_busy), 40'(m_busy));
         checkOutput("done", 40'(o_done), 40'(m_done));
         checkOutput("bcd",  o_bcd, m_bcd);
      end
   end

   task automatic applyStimulus(input logic [DATA_W-1:0] v);
      @(posedge i_clk);
      #2;
      i_bin   = v;
      i_valid = 1'b1;
   endtask

   task automatic waitDone(output int cyc);
      bit ok;
      ok  = 1'b0;
      cyc = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk);
         cyc++;
         @(negedge i_clk);
         if (o_done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL done_timeout: got no o_done, expected o_done within 40 clocks");
      end
   endtask

   task automatic dropValid(input int extra);
      @(posedge i_clk);
      #2;
      i_valid = 1'b0;
      repeat (extra) @(posedge i_clk);
   endtask

   task automatic convCheck(input string name, input logic [DATA_W-1:0] v,
                            input logic [4*DIGITS-1:0] exp);
      int cyc;
      applyStimulus(v);
      waitDone(cyc);
      checkOutput({name, "_lat"}, 40'(cyc), 40'd31);
      checkOutput({name, "_bcd"}, o_bcd, exp);
      dropValid(0);
   endtask

   initial begin
      int cyc;
      logic [DATA_W-1:0] v;

      i_rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("rst_busy", 40'(o_busy), 40'd0);
      checkOutput("rst_done", 40'(o_done), 40'd0);
      checkOutput("rst_bcd",  o_bcd, 40'd0);
      chk_en = 1'b1;
      #1 i_rst_n = 1'b1;

      convCheck("v81",  30'd81, pick(40'h0000000081, 40'hFFFFFFFF81));
      convCheck("vmax", 30'h3FFFFFFF, pick(40'h1073741823, 40'h1073741823));
      convCheck("v0",   30'd0, pick(40'h0000000000, 40'hFFFFFFFFF0));
      convCheck("v15p7", 30'd170859375, pick(40'h0170859375, 40'hF170859375));

      // held i_valid with i_bin changing mid-conversion
      applyStimulus(30'd999999);
      repeat (5) @(posedge i_clk);
      #2 i_bin = 30'd12345;
      waitDone(cyc);
      checkOutput("hold_bcd", o_bcd, pick(40'h0000999999, 40'hFFFF999999));
      repeat (20) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("hold_done", 40'(o_done), 40'd1);
      dropValid(0);
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("drop_done", 40'(o_done), 40'd0);
      checkOutput("drop_bcd",  o_bcd, pick(40'h0000999999, 40'hFFFF999999));

      // reset mid-conversion, released with i_valid low
      applyStimulus(30'd123456);
      repeat (12) @(posedge i_clk);
      @(negedge i_clk);
      #1 i_rst_n = 1'b0;
      i_valid = 1'b0;
      #1;
      checkOutput("abort_busy", 40'(o_busy), 40'd0);
      checkOutput("abort_done", 40'(o_done), 40'd0);
      checkOutput("abort_bcd",  o_bcd, 40'd0);
      @(negedge i_clk);
      #1 i_rst_n = 1'b1;
      repeat (35) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("abort_nodone", 40'(o_done), 40'd0);

      // reset released with i_valid already high starts a conversion
      #1 i_rst_n = 1'b0;
      i_valid = 1'b1;
      i_bin   = 30'd4321;
      @(negedge i_clk);
      #1 i_rst_n = 1'b1;
      waitDone(cyc);
      checkOutput("rel_lat", 40'(cyc), 40'd31);
      checkOutput("rel_bcd", o_bcd, pick(40'h0000004321, 40'hFFFFFF4321));
      dropValid(0);

      // back-to-back with one low cycle between
      applyStimulus(30'd77);
      waitDone(cyc);
      dropValid(0);
      convCheck("b2b", 30'd1000, pick(40'h0000001000, 40'hFFFFFF1000));

      // randomized conversions against the model
      for (int n = 0; n < 20; n++) begin
         v = 30'($urandom);
         if (n % 5 == 0) v = 30'($urandom_range(0, 999));
         applyStimulus(v);
         waitDone(cyc);
         checkOutput("rnd_lat", 40'(cyc), 40'd31);
         repeat ($urandom_range(0, 4)) @(posedge i_clk);
         dropValid($urandom_range(0, 3));
      end

      repeat (3) @(posedge i_clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
